// File: rtl/alu_pkg.sv
// Shared opcodes, sequencer states and opcode helpers
// for the ALU issue/writeback slice.
package alu_pkg;

  localparam logic [3:0] OP_OR  = 4'h0;
  localparam logic [3:0] OP_XOR = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SAR = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_MOD = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  function automatic logic op_is_valid(
    input logic [3:0] op
  );
    case (op)
      OP_OR, OP_XOR, OP_AND,
      OP_ADD, OP_SUB, OP_MUL,
      OP_SHL, OP_SAR,
      OP_DIV, OP_MOD: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_div(
    input logic [3:0] op
  );
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_issue_writeback_decode.sv
// Suppression check: unknown opcode, or a divide
// with a zero divisor when the check is enabled.
module issue_decode
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit CHECK_DIV0 = 1'b1
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              suppress_o
);

  logic bad_op;
  logic div0;

  assign bad_op = !op_is_valid(op_i);
  assign div0   = CHECK_DIV0
               && op_is_div(op_i)
               && (b_i == '0);

  assign suppress_o = bad_op || div0;

endmodule

// File: rtl/alu_issue_writeback.sv
// Single-slot sequencer: reg-file read, ALU execute,
// reg-file writeback; one instruction per 4 cycles.
module alu_issue_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter bit CHECK_DIV0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs0,
  input  logic [ADDR_W-1:0] in_rs1,
  output logic [ADDR_W-1:0] rf_r0,
  output logic [ADDR_W-1:0] rf_r1,
  input  logic [DATA_W-1:0] rf_d0,
  input  logic [DATA_W-1:0] rf_d1,
  output logic [ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0] rf_dw,
  output logic              rf_we,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_dout,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  logic              rdy_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] r0_q;
  logic [ADDR_W-1:0] r1_q;
  logic [ADDR_W-1:0] rw_q;
  logic [DATA_W-1:0] dw_q;
  logic              we_q;
  logic [3:0]        aop_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              done_q;
  logic              err_q;
  logic              suppress;

  // Operates on the EXEC-stage operands.
  issue_decode #(
    .DATA_W     (DATA_W),
    .CHECK_DIV0 (CHECK_DIV0)
  ) u_decode (
    .op_i       (aop_q),
    .b_i        (b_q),
    .suppress_o (suppress)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b1;
      op_q    <= '0;
      rd_q    <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      rw_q    <= '0;
      dw_q    <= '0;
      we_q    <= 1'b0;
      aop_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            rd_q    <= in_rd;
            r0_q    <= in_rs0;
            r1_q    <= in_rs1;
            rdy_q   <= 1'b0;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          a_q     <= rf_d0;
          b_q     <= rf_d1;
          aop_q   <= op_q;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          rw_q    <= rd_q;
          dw_q    <= alu_dout;
          we_q    <= !suppress;
          done_q  <= 1'b1;
          err_q   <= suppress;
          state_q <= ST_WB;
        end
        ST_WB: begin
          rdy_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = rdy_q;
  assign rf_r0    = r0_q;
  assign rf_r1    = r1_q;
  assign rf_rw    = rw_q;
  assign rf_dw    = dw_q;
  assign rf_we    = we_q;
  assign alu_op   = aop_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_issue_writeback.sv
// Directed bench: two instances (div-by-zero check on/off)
// around a reg-file model and a behavioural ALU.
module tb_alu_issue_writeback;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid;
  logic [3:0]  in_op;
  logic [5:0]  in_rd, in_rs0, in_rs1;

  logic        rdy_p, we_p, done_p, err_p;
  logic [5:0]  r0_p, r1_p, rw_p;
  logic [31:0] dw_p, aa_p, ab_p, d0_p, d1_p, dout_p;
  logic [3:0]  aop_p;

  logic        rdy_n, we_n, done_n, err_n;
  logic [5:0]  r0_n, r1_n, rw_n;
  logic [31:0] dw_n, aa_n, ab_n, d0_n, d1_n, dout_n;
  logic [3:0]  aop_n;

  logic        ld_en;
  logic [5:0]  ld_a;
  logic [31:0] ld_d;
  logic [31:0] rfp [64];
  logic [31:0] rfn [64];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] dw;
    logic [5:0]  rw;
    logic        we_p;
    logic        we_n;
    logic [31:0] dw_n;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] alu_f(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    case (op)
      4'h0: return a | b;
      4'h1: return a ^ b;
      4'h2: return a & b;
      4'h4: return a + b;
      4'h5: return a - b;
      4'h6: return a * b;
      4'h8: return a << b[4:0];
      4'h9: return $unsigned($signed(a) >>> b[4:0]);
      4'hA: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hB: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  assign d0_p   = rfp[r0_p];
  assign d1_p   = rfp[r1_p];
  assign d0_n   = rfn[r0_n];
  assign d1_n   = rfn[r1_n];
  assign dout_p = alu_f(aop_p, aa_p, ab_p);
  assign dout_n = alu_f(aop_n, aa_n, ab_n);

  always @(posedge clk) begin
    if (we_p) rfp[rw_p] <= dw_p;
    if (we_n) rfn[rw_n] <= dw_n;
    if (ld_en) begin
      rfp[ld_a] <= ld_d;
      rfn[ld_a] <= ld_d;
    end
  end

  alu_issue_writeback #(
    .DATA_W(32), .ADDR_W(6), .CHECK_DIV0(1'b1)
  ) u_p (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_p),
    .in_op(in_op), .in_rd(in_rd),
    .in_rs0(in_rs0), .in_rs1(in_rs1),
    .rf_r0(r0_p), .rf_r1(r1_p),
    .rf_d0(d0_p), .rf_d1(d1_p),
    .rf_rw(rw_p), .rf_dw(dw_p), .rf_we(we_p),
    .alu_op(aop_p), .alu_a(aa_p), .alu_b(ab_p),
    .alu_dout(dout_p),
    .done(done_p), .err(err_p)
  );

  alu_issue_writeback #(
    .DATA_W(32), .ADDR_W(6), .CHECK_DIV0(1'b0)
  ) u_n (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_n),
    .in_op(in_op), .in_rd(in_rd),
    .in_rs0(in_rs0), .in_rs1(in_rs1),
    .rf_r0(r0_n), .rf_r1(r1_n),
    .rf_d0(d0_n), .rf_d1(d1_n),
    .rf_rw(rw_n), .rf_dw(dw_n), .rf_we(we_n),
    .alu_op(aop_n), .alu_a(aa_n), .alu_b(ab_n),
    .alu_dout(dout_n),
    .done(done_n), .err(err_n)
  );

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  function automatic exp_t mk(
    input logic [31:0] dw,
    input logic [5:0]  rw,
    input logic        wp,
    input logic        wn,
    input logic [31:0] dn
  );
    exp_t e;
    e.dw = dw; e.rw = rw;
    e.we_p = wp; e.we_n = wn; e.dw_n = dn;
    return e;
  endfunction

  task automatic ld(input logic [5:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Caller is at a negedge; returns at the WB negedge.
  task automatic issue(
    input logic [3:0] op,
    input logic [5:0] rd,
    input logic [5:0] rs0,
    input logic [5:0] rs1,
    input exp_t       e,
    input bit         keep
  );
    int w;
    int lat;
    exp_t x;
    sb.push_back(e);
    in_valid = 1'b1; in_op = op;
    in_rd = rd; in_rs0 = rs0; in_rs1 = rs1;
    w = 0;
    while (!rdy_p && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("accept", {31'b0, rdy_p}, 32'd1);
    if (!rdy_p) begin
      void'(sb.pop_front());
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
    chk("rdy_read", {31'b0, rdy_p}, 32'd0);
    chk("rf_r0", {26'b0, r0_p}, {26'b0, rs0});
    chk("rf_r1", {26'b0, r1_p}, {26'b0, rs1});
    @(negedge clk);
    chk("rdy_exec", {31'b0, rdy_p}, 32'd0);
    chk("alu_op", {28'b0, aop_p}, {28'b0, op});
    lat = 2;
    while (!done_p && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 32'd3);
    chk("rdy_wb", {31'b0, rdy_p}, 32'd0);
    x = sb.pop_front();
    chk("done", {31'b0, done_p}, 32'd1);
    chk("we", {31'b0, we_p}, {31'b0, x.we_p});
    chk("err", {31'b0, err_p}, {31'b0, !x.we_p});
    if (x.we_p) begin
      chk("rw", {26'b0, rw_p}, {26'b0, x.rw});
      chk("dw", dw_p, x.dw);
    end
    chk("we_nochk", {31'b0, we_n}, {31'b0, x.we_n});
    chk("err_nochk", {31'b0, err_n}, {31'b0, !x.we_n});
    if (x.we_n) chk("dw_nochk", dw_n, x.dw_n);
  endtask

  initial begin
    in_valid = 1'b0; in_op = '0;
    in_rd = '0; in_rs0 = '0; in_rs1 = '0;
    ld_en = 1'b0; ld_a = '0; ld_d = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, rdy_p}, 32'd1);
    chk("rst_we", {31'b0, we_p}, 32'd0);
    chk("rst_done", {31'b0, done_p}, 32'd0);
    chk("rst_err", {31'b0, err_p}, 32'd0);
    chk("rst_r0", {26'b0, r0_p}, 32'd0);
    chk("rst_rw", {26'b0, rw_p}, 32'd0);
    chk("rst_dw", dw_p, 32'd0);
    chk("rst_a", aa_p, 32'd0);

    ld(1, 32'd7); ld(2, 32'd5); ld(3, 32'd0);
    issue(OP_ADD, 3, 1, 2, mk(32'd12, 3, 1, 1, 32'd12), 0);

    ld(1, 32'h8000_0000); ld(2, 32'd4);
    issue(OP_SAR, 4, 1, 2,
          mk(32'hF800_0000, 4, 1, 1, 32'hF800_0000), 0);
    issue(OP_SHL, 5, 1, 2, mk(32'h0, 5, 1, 1, 32'h0), 0);

    ld(1, 32'd100); ld(2, 32'd0); ld(6, 32'h66);
    issue(OP_DIV, 6, 1, 2,
          mk(32'h0, 6, 0, 1, 32'hFFFF_FFFF), 0);
    @(negedge clk);
    chk("r6_kept", rfp[6], 32'h66);
    chk("r6_nochk", rfn[6], 32'hFFFF_FFFF);

    ld(1, 32'd7); ld(2, 32'd5); ld(8, 32'h88);
    issue(4'h7, 8, 1, 2, mk(32'h0, 8, 0, 0, 32'h0), 0);
    @(negedge clk);
    chk("r8_kept", rfp[8], 32'h88);
    issue(OP_SUB, 8, 1, 2, mk(32'd2, 8, 1, 1, 32'd2), 0);

    ld(1, 32'd3); ld(2, 32'd3);
    issue(OP_MUL, 1, 1, 2, mk(32'd9, 1, 1, 1, 32'd9), 1);
    issue(OP_ADD, 9, 1, 2, mk(32'd12, 9, 1, 1, 32'd12), 0);

    // Reset while the ADD is in EXEC.
    ld(10, 32'hA5);
    in_valid = 1'b1; in_op = OP_ADD;
    in_rd = 6'd10; in_rs0 = 6'd1; in_rs1 = 6'd2;
    for (int w = 0; w < 10 && !rdy_p; w++) @(negedge clk);
    chk("rst_accept", {31'b0, rdy_p}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_exec_op", {28'b0, aop_p}, {28'b0, OP_ADD});
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_we", {31'b0, we_p}, 32'd0);
    chk("mid_done", {31'b0, done_p}, 32'd0);
    chk("mid_ready", {31'b0, rdy_p}, 32'd1);
    chk("mid_op", {28'b0, aop_p}, 32'd0);
    chk("mid_a", aa_p, 32'd0);
    chk("mid_dw", dw_p, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ready", {31'b0, rdy_p}, 32'd1);
    chk("post_done", {31'b0, done_p}, 32'd0);
    @(negedge clk);
    chk("r10_kept", rfp[10], 32'hA5);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
